// File: rtl/mixed_precision_csr.sv
// Mixed-precision CSR (0x00D): sub-word cycle, vector format and skip size.
// Closes the loop with mixed_precision_controller and flags group completion.
module mixed_precision_csr #(
   parameter int unsigned NBITS_MIXED_CYCLES = 3,
   parameter int unsigned IVEC_FMT_W         = 3,
   parameter int unsigned NBITS_MAX_KER      = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          csr_access_i,
   input  logic [1:0]                    csr_op_i,
   input  logic [11:0]                   csr_addr_i,
   input  logic [31:0]                   csr_wdata_i,
   output logic [31:0]                   csr_rdata_o,
   input  logic                          mpc_we_i,
   input  logic [NBITS_MIXED_CYCLES-1:0] mpc_next_cycle_i,
   output logic [NBITS_MIXED_CYCLES-1:0] current_cycle_o,
   output logic [IVEC_FMT_W-1:0]         ivec_fmt_o,
   output logic [NBITS_MAX_KER-1:0]      skip_size_o,
   output logic                          group_done_o
);

   localparam logic [11:0] CSR_MIXED = 12'h00D;
   localparam int unsigned SW        = NBITS_MIXED_CYCLES + 1;

   typedef enum logic [IVEC_FMT_W-1:0] {
      MIXED_NONE = IVEC_FMT_W'(0),
      MIXED_2x4  = IVEC_FMT_W'(1),
      MIXED_2x8  = IVEC_FMT_W'(2),
      MIXED_2x16 = IVEC_FMT_W'(3),
      MIXED_4x8  = IVEC_FMT_W'(4),
      MIXED_4x16 = IVEC_FMT_W'(5),
      MIXED_8x16 = IVEC_FMT_W'(6)
   } ivec_mode_fmt;

   function automatic logic [SW-1:0] span_of(input logic [IVEC_FMT_W-1:0] f);
      case (f)
         MIXED_2x4, MIXED_4x8, MIXED_8x16: span_of = SW'(2);
         MIXED_2x8, MIXED_4x16:            span_of = SW'(4);
         MIXED_2x16:                       span_of = SW'(8);
         default:                          span_of = SW'(1);
      endcase
   endfunction

   logic [NBITS_MIXED_CYCLES-1:0] cycle_q;
   ivec_mode_fmt                  fmt_q;
   logic [NBITS_MAX_KER-1:0]      skip_q;
   logic                          gd_q;

   logic [31:0]                   img;
   logic [31:0]                   new_img;
   logic                          sw_we;
   logic [IVEC_FMT_W-1:0]         new_fmt;
   logic [NBITS_MIXED_CYCLES-1:0] new_cycle_raw;
   logic [NBITS_MIXED_CYCLES-1:0] new_cycle;
   logic [NBITS_MAX_KER-1:0]      new_skip;
   logic [SW-1:0]                 cur_span;
   logic [NBITS_MIXED_CYCLES-1:0] mpc_cycle;
   logic                          mpc_wrap;

   always_comb begin
      img = '0;
      img[NBITS_MIXED_CYCLES-1:0] = cycle_q;
      img[4 +: IVEC_FMT_W]        = fmt_q;
      img[8 +: NBITS_MAX_KER]     = skip_q;

      csr_rdata_o = (csr_addr_i == CSR_MIXED) ? img : '0;
      sw_we       = csr_access_i && (csr_addr_i == CSR_MIXED) && (csr_op_i != 2'b00);

      case (csr_op_i)
         2'b01:   new_img = csr_wdata_i;
         2'b10:   new_img = img | csr_wdata_i;
         2'b11:   new_img = img & ~csr_wdata_i;
         default: new_img = img;
      endcase

      new_fmt       = new_img[4 +: IVEC_FMT_W];
      new_skip      = new_img[8 +: NBITS_MAX_KER];
      new_cycle_raw = new_img[NBITS_MIXED_CYCLES-1:0];
      // Cycle is clamped against the span of the format being written, not the old one
      new_cycle     = ({1'b0, new_cycle_raw} < span_of(new_fmt)) ? new_cycle_raw : '0;

      cur_span  = span_of(fmt_q);
      mpc_cycle = ({1'b0, mpc_next_cycle_i} < cur_span) ? mpc_next_cycle_i : '0;
      mpc_wrap  = (cur_span != SW'(1)) && (cycle_q != '0) && (mpc_cycle == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q <= '0;
         fmt_q   <= MIXED_NONE;
         skip_q  <= '0;
         gd_q    <= 1'b0;
      end else begin
         gd_q <= 1'b0;
         if (sw_we) begin
            cycle_q <= new_cycle;
            fmt_q   <= ivec_mode_fmt'(new_fmt);
            skip_q  <= new_skip;
         end else if (mpc_we_i) begin
            cycle_q <= mpc_cycle;
            gd_q    <= mpc_wrap;
         end
      end
   end

   assign current_cycle_o = cycle_q;
   assign ivec_fmt_o      = fmt_q;
   assign skip_size_o     = skip_q;
   assign group_done_o    = gd_q;

endmodule

// File: tb/tb_mixed_precision_csr.sv
// Scoreboard bench for mixed_precision_csr: per-cycle expectations queued on drive, popped after the edge.
// Format encoding: 0 none, 1 2x4, 2 2x8, 3 2x16, 4 4x8, 5 4x16, 6 8x16, 7 reserved.
module tb_mixed_precision_csr;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_access_i;
   logic [1:0]  csr_op_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic [31:0] csr_rdata_o;
   logic        mpc_we_i;
   logic [2:0]  mpc_next_cycle_i;
   logic [2:0]  current_cycle_o;
   logic [2:0]  ivec_fmt_o;
   logic [7:0]  skip_size_o;
   logic        group_done_o;

   int checks = 0;
   int errors = 0;

   localparam logic [11:0] A = 12'h00D;

   always #5 clk = ~clk;

   mixed_precision_csr #(
      .NBITS_MIXED_CYCLES(3),
      .IVEC_FMT_W        (3),
      .NBITS_MAX_KER     (8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .csr_access_i    (csr_access_i),
      .csr_op_i        (csr_op_i),
      .csr_addr_i      (csr_addr_i),
      .csr_wdata_i     (csr_wdata_i),
      .csr_rdata_o     (csr_rdata_o),
      .mpc_we_i        (mpc_we_i),
      .mpc_next_cycle_i(mpc_next_cycle_i),
      .current_cycle_o (current_cycle_o),
      .ivec_fmt_o      (ivec_fmt_o),
      .skip_size_o     (skip_size_o),
      .group_done_o    (group_done_o)
   );

   typedef struct {
      logic        rs;
      logic        acc;
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wd;
      logic        mwe;
      logic [2:0]  mnc;
      logic [46:0] exp;
   } row_t;

   logic [46:0] sb[$];

   function automatic logic [31:0] img(input logic [2:0] c, input logic [2:0] f, input logic [7:0] s);
      return {16'h0, s, 1'b0, f, 1'b0, c};
   endfunction

   // Expected vector: {cycle, fmt, skip, group_done, rdata seen with this row's address}
   function automatic row_t r(input logic rs, input logic acc, input logic [1:0] op,
                              input logic [11:0] addr, input logic [31:0] wd,
                              input logic mwe, input logic [2:0] mnc,
                              input logic [2:0] c, input logic [2:0] f,
                              input logic [7:0] s, input logic g);
      row_t x;
      x.rs = rs; x.acc = acc; x.op = op; x.addr = addr; x.wd = wd;
      x.mwe = mwe; x.mnc = mnc;
      x.exp = {c, f, s, g, (addr == A) ? img(c, f, s) : 32'h0};
      return x;
   endfunction

   task automatic apply(input row_t x);
      rst = x.rs; csr_access_i = x.acc; csr_op_i = x.op; csr_addr_i = x.addr;
      csr_wdata_i = x.wd; mpc_we_i = x.mwe; mpc_next_cycle_i = x.mnc;
   endtask

   task automatic idle();
      apply(r(1'b0, 1'b0, 2'b00, A, 32'h0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0));
   endtask

   task automatic test_reset();
      row_t rows[$];
      logic [46:0] e, got;
      rows.push_back(r(1, 0, 0, A, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(r(1, 0, 0, A, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(r(0, 0, 0, A, 0, 0, 0, 0, 0, 0, 0));
      foreach (rows[i]) begin
         apply(rows[i]); sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = {current_cycle_o, ivec_fmt_o, skip_size_o, group_done_o, csr_rdata_o};
         e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reset step %0d: got %h expected %h {cyc,fmt,skip,gd,rdata}", i, got, e);
         end
      end
      idle();
   endtask

   task automatic test_sw_write();
      row_t rows[$];
      logic [46:0] e, got;
      rows.push_back(r(0, 1, 2'b01, A, 32'hABCD_03AA, 0, 0, 2, 2, 3, 0));
      rows.push_back(r(0, 1, 2'b00, A, 32'hFFFF_FFFF, 0, 0, 2, 2, 3, 0));
      rows.push_back(r(0, 1, 2'b01, 12'h00C, 32'h0, 0, 0, 2, 2, 3, 0));
      rows.push_back(r(0, 1, 2'b11, 12'h10D, 32'hFFFF, 0, 0, 2, 2, 3, 0));
      rows.push_back(r(0, 0, 2'b01, A, 32'h0, 0, 0, 2, 2, 3, 0));
      foreach (rows[i]) begin
         apply(rows[i]); sb.push_back(rows[i].exp);
         if (i == 0) begin
            #1; checks++;
            if (csr_rdata_o !== 32'h0) begin
               errors++;
               $display("FAIL sw_write pre-write rdata: got %h expected %h", csr_rdata_o, 32'h0);
            end
         end
         @(posedge clk); #1;
         got = {current_cycle_o, ivec_fmt_o, skip_size_o, group_done_o, csr_rdata_o};
         e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL sw_write step %0d: got %h expected %h {cyc,fmt,skip,gd,rdata}", i, got, e);
         end
      end
      idle();
   endtask

   task automatic test_clamp();
      row_t rows[$];
      logic [46:0] e, got;
      rows.push_back(r(0, 1, 2'b01, A, 32'h15, 0, 0, 0, 1, 0, 0));
      rows.push_back(r(0, 1, 2'b10, A, 32'h1,  0, 0, 1, 1, 0, 0));
      rows.push_back(r(0, 1, 2'b11, A, 32'h1,  0, 0, 0, 1, 0, 0));
      rows.push_back(r(0, 1, 2'b10, A, 32'h1,  0, 0, 1, 1, 0, 0));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0,  1, 5, 0, 1, 0, 1));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0,  0, 0, 0, 1, 0, 0));
      rows.push_back(r(0, 1, 2'b01, A, 32'h100, 0, 0, 0, 0, 1, 0));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0,  1, 3, 0, 0, 1, 0));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0,  1, 0, 0, 0, 1, 0));
      rows.push_back(r(0, 1, 2'b01, A, 32'h71, 0, 0, 0, 7, 0, 0));
      rows.push_back(r(0, 1, 2'b01, A, 32'h42, 0, 0, 0, 4, 0, 0));
      foreach (rows[i]) begin
         apply(rows[i]); sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = {current_cycle_o, ivec_fmt_o, skip_size_o, group_done_o, csr_rdata_o};
         e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL clamp step %0d: got %h expected %h {cyc,fmt,skip,gd,rdata}", i, got, e);
         end
      end
      idle();
   endtask

   task automatic test_group_wrap();
      row_t rows[$];
      logic [46:0] e, got;
      rows.push_back(r(0, 1, 2'b01, A, 32'h130, 0, 0, 0, 3, 1, 0));
      for (int k = 1; k <= 7; k++)
         rows.push_back(r(0, 0, 2'b00, A, 32'h0, 1, 3'(k), 3'(k), 3, 1, 0));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0, 1, 0, 0, 3, 1, 1));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0, 0, 0, 0, 3, 1, 0));
      rows.push_back(r(0, 1, 2'b01, A, 32'h51, 0, 0, 1, 5, 0, 0));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0, 1, 2, 2, 5, 0, 0));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0, 1, 3, 3, 5, 0, 0));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0, 1, 0, 0, 5, 0, 1));
      rows.push_back(r(0, 1, 2'b01, A, 32'h23, 0, 0, 3, 2, 0, 0));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0, 1, 4, 0, 2, 0, 1));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0, 0, 0, 0, 2, 0, 0));
      foreach (rows[i]) begin
         apply(rows[i]); sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = {current_cycle_o, ivec_fmt_o, skip_size_o, group_done_o, csr_rdata_o};
         e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL group_wrap step %0d: got %h expected %h {cyc,fmt,skip,gd,rdata}", i, got, e);
         end
      end
      idle();
   endtask

   task automatic test_simultaneous();
      row_t rows[$];
      logic [46:0] e, got;
      rows.push_back(r(0, 1, 2'b01, A, 32'h30, 0, 0, 0, 3, 0, 0));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0,  1, 7, 7, 3, 0, 0));
      rows.push_back(r(0, 1, 2'b01, A, 32'h33, 1, 0, 3, 3, 0, 0));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0,  0, 0, 3, 3, 0, 0));
      rows.push_back(r(0, 1, 2'b01, A, 32'h10, 0, 0, 0, 1, 0, 0));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0,  0, 0, 0, 1, 0, 0));
      foreach (rows[i]) begin
         apply(rows[i]); sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = {current_cycle_o, ivec_fmt_o, skip_size_o, group_done_o, csr_rdata_o};
         e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL simultaneous step %0d: got %h expected %h {cyc,fmt,skip,gd,rdata}", i, got, e);
         end
      end
      idle();
   endtask

   task automatic test_reset_mid_group();
      row_t rows[$];
      logic [46:0] e, got;
      rows.push_back(r(0, 1, 2'b01, A, 32'h53, 0, 0, 3, 5, 0, 0));
      rows.push_back(r(1, 0, 2'b00, A, 32'h0,  1, 0, 0, 0, 0, 0));
      rows.push_back(r(0, 0, 2'b00, A, 32'h0,  0, 0, 0, 0, 0, 0));
      foreach (rows[i]) begin
         apply(rows[i]); sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = {current_cycle_o, ivec_fmt_o, skip_size_o, group_done_o, csr_rdata_o};
         e = sb.pop_front(); checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reset_mid step %0d: got %h expected %h {cyc,fmt,skip,gd,rdata}", i, got, e);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_sw_write();
      test_clamp();
      test_group_wrap();
      test_simultaneous();
      test_reset_mid_group();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
